// File: rtl/store_commit_buffer.sv
// Purpose: in-order queue of committed stores draining to the D-cache, with store-to-load forwarding.
// Latency: a push is visible on dc_req_* and to forwarding one cycle later; forwarding is combinational.
// Backpressure: dc_req_ready low holds the head stable; st_stall (full) stalls the ROB, and a push while full is dropped and flags overflow.
module store_commit_buffer #(
    parameter int DEPTH      = 4,
    parameter int ADDR_WIDTH = 26,
    parameter int DATA_WIDTH = 32
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       mem_wr_en,
    input  logic [ADDR_WIDTH-1:0]      mem_wr_addr,
    input  logic [DATA_WIDTH-1:0]      mem_wr_data,
    output logic                       st_stall,
    output logic                       dc_req_valid,
    output logic [ADDR_WIDTH-1:0]      dc_req_addr,
    output logic [DATA_WIDTH-1:0]      dc_req_data,
    input  logic                       dc_req_ready,
    input  logic                       ld_valid,
    input  logic [ADDR_WIDTH-1:0]      ld_addr,
    output logic                       fwd_hit,
    output logic [DATA_WIDTH-1:0]      fwd_data,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       overflow
);

    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] PTR_ONE = 1;

    logic [ADDR_WIDTH-1:0] addr_q [DEPTH];
    logic [ADDR_WIDTH-1:0] addr_d [DEPTH];
    logic [DATA_WIDTH-1:0] data_q [DEPTH];
    logic [DATA_WIDTH-1:0] data_d [DEPTH];
    logic [DEPTH-1:0]      vld_q, vld_d;
    logic [PW:0]           wr_ptr_q, wr_ptr_d;
    logic [PW:0]           rd_ptr_q, rd_ptr_d;
    logic                  overflow_q, overflow_d;

    logic [PW-1:0] wr_idx, rd_idx, scan_idx;
    logic          full, push, pop;

    // Pointer decode: MSB is the wrap bit, so equal low bits mean empty or full.
    assign wr_idx = wr_ptr_q[PW-1:0];
    assign rd_idx = rd_ptr_q[PW-1:0];
    assign empty  = (wr_ptr_q == rd_ptr_q);
    assign full   = (wr_idx == rd_idx) && (wr_ptr_q[PW] != rd_ptr_q[PW]);
    assign count  = wr_ptr_q - rd_ptr_q;

    assign st_stall     = full;
    assign overflow     = overflow_q;
    assign dc_req_valid = !empty;
    assign dc_req_addr  = dc_req_valid ? addr_q[rd_idx] : '0;
    assign dc_req_data  = dc_req_valid ? data_q[rd_idx] : '0;

    assign push = mem_wr_en && !full;
    assign pop  = dc_req_valid && dc_req_ready;

    // Next-state: write the tail on push, retire the head on pop, latch overflow on a rejected push.
    always_comb begin
        addr_d     = addr_q;
        data_d     = data_q;
        vld_d      = vld_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        overflow_d = overflow_q;
        if (push) begin
            addr_d[wr_idx] = mem_wr_addr;
            data_d[wr_idx] = mem_wr_data;
            vld_d[wr_idx]  = 1'b1;
            wr_ptr_d       = wr_ptr_q + PTR_ONE;
        end
        if (pop) begin
            vld_d[rd_idx] = 1'b0;
            rd_ptr_d      = rd_ptr_q + PTR_ONE;
        end
        if (mem_wr_en && full) begin
            overflow_d = 1'b1;
        end
    end

    // Forwarding: walk oldest to youngest so the last match (youngest) wins; only stored entries count.
    always_comb begin
        fwd_hit  = 1'b0;
        fwd_data = '0;
        scan_idx = '0;
        for (int i = 0; i < DEPTH; i++) begin
            scan_idx = rd_idx + PW'(i);
            if (ld_valid && vld_q[scan_idx] && (addr_q[scan_idx] == ld_addr)) begin
                fwd_hit  = 1'b1;
                fwd_data = data_q[scan_idx];
            end
        end
    end

    // State registers; reset drops every queued store, including an unaccepted head.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            addr_q     <= '{default: '0};
            data_q     <= '{default: '0};
            vld_q      <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            overflow_q <= 1'b0;
        end else begin
            addr_q     <= addr_d;
            data_q     <= data_d;
            vld_q      <= vld_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            overflow_q <= overflow_d;
        end
    end

endmodule

// File: tb/tb_store_commit_buffer.sv
// Purpose: directed table plus hand-written sequences for store_commit_buffer (DEPTH=4).
// Latency: each row applies inputs, checks pre-edge outputs, then clocks once.
// Backpressure: dc_req_ready is driven from the table or randomly during streaming.
module tb_store_commit_buffer;

    localparam int DEPTH = 4;
    localparam int AW    = 26;
    localparam int DW    = 32;

    logic          clk;
    logic          rst_n;
    logic          mem_wr_en;
    logic [AW-1:0] mem_wr_addr;
    logic [DW-1:0] mem_wr_data;
    logic          st_stall;
    logic          dc_req_valid;
    logic [AW-1:0] dc_req_addr;
    logic [DW-1:0] dc_req_data;
    logic          dc_req_ready;
    logic          ld_valid;
    logic [AW-1:0] ld_addr;
    logic          fwd_hit;
    logic [DW-1:0] fwd_data;
    logic          empty;
    logic [2:0]    count;
    logic          overflow;

    int checks   = 0;
    int failures = 0;

    store_commit_buffer #(.DEPTH(DEPTH), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .mem_wr_en    (mem_wr_en),
        .mem_wr_addr  (mem_wr_addr),
        .mem_wr_data  (mem_wr_data),
        .st_stall     (st_stall),
        .dc_req_valid (dc_req_valid),
        .dc_req_addr  (dc_req_addr),
        .dc_req_data  (dc_req_data),
        .dc_req_ready (dc_req_ready),
        .ld_valid     (ld_valid),
        .ld_addr      (ld_addr),
        .fwd_hit      (fwd_hit),
        .fwd_data     (fwd_data),
        .empty        (empty),
        .count        (count),
        .overflow     (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic          we;
        logic [AW-1:0] wa;
        logic [DW-1:0] wd;
        logic          rdy;
        logic          ldv;
        logic [AW-1:0] lda;
        logic          e_vld;
        logic [AW-1:0] e_addr;
        logic [DW-1:0] e_data;
        int            e_cnt;
        logic          e_stall;
        logic          e_hit;
        logic [DW-1:0] e_fwd;
        logic          e_ovf;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic we, logic [AW-1:0] wa, logic [DW-1:0] wd, logic rdy,
                                logic ldv, logic [AW-1:0] lda, logic e_vld, logic [AW-1:0] e_addr,
                                logic [DW-1:0] e_data, int e_cnt, logic e_stall, logic e_hit,
                                logic [DW-1:0] e_fwd, logic e_ovf);
        vec_t v;
        v.we = we; v.wa = wa; v.wd = wd; v.rdy = rdy; v.ldv = ldv; v.lda = lda;
        v.e_vld = e_vld; v.e_addr = e_addr; v.e_data = e_data; v.e_cnt = e_cnt;
        v.e_stall = e_stall; v.e_hit = e_hit; v.e_fwd = e_fwd; v.e_ovf = e_ovf;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    task automatic idle_inputs();
        mem_wr_en    = 1'b0;
        mem_wr_addr  = '0;
        mem_wr_data  = '0;
        dc_req_ready = 1'b0;
        ld_valid     = 1'b0;
        ld_addr      = '0;
    endtask

    // Advance one clock and land 1ns after the edge, where inputs are driven.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    int rx, sent, mcnt;
    logic pop_now, push_now;

    initial begin
        idle_inputs();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;

        // mk(we, wa, wd, rdy, ldv, lda, e_vld, e_addr, e_data, e_cnt, e_stall, e_hit, e_fwd, e_ovf)
        vecs.push_back(mk(0, 'h00, 'h0,        0, 0, 'h00, 0, 'h00, 'h0,        0, 0, 0, 'h0,        0));
        vecs.push_back(mk(1, 'h10, 'hAAAA0001, 0, 0, 'h00, 0, 'h00, 'h0,        0, 0, 0, 'h0,        0));
        vecs.push_back(mk(0, 'h00, 'h0,        1, 1, 'h10, 1, 'h10, 'hAAAA0001, 1, 0, 1, 'hAAAA0001, 0));
        vecs.push_back(mk(0, 'h00, 'h0,        0, 1, 'h10, 0, 'h00, 'h0,        0, 0, 0, 'h0,        0));
        vecs.push_back(mk(1, 'h01, 'h101,      0, 0, 'h00, 0, 'h00, 'h0,        0, 0, 0, 'h0,        0));
        vecs.push_back(mk(1, 'h02, 'h102,      0, 0, 'h00, 1, 'h01, 'h101,      1, 0, 0, 'h0,        0));
        vecs.push_back(mk(1, 'h03, 'h103,      0, 0, 'h00, 1, 'h01, 'h101,      2, 0, 0, 'h0,        0));
        vecs.push_back(mk(1, 'h04, 'h104,      0, 0, 'h00, 1, 'h01, 'h101,      3, 0, 0, 'h0,        0));
        vecs.push_back(mk(1, 'h05, 'h105,      0, 0, 'h00, 1, 'h01, 'h101,      4, 1, 0, 'h0,        0));
        vecs.push_back(mk(1, 'h06, 'h106,      1, 1, 'h04, 1, 'h01, 'h101,      4, 1, 1, 'h104,      1));
        vecs.push_back(mk(0, 'h00, 'h0,        0, 1, 'h05, 1, 'h02, 'h102,      3, 0, 0, 'h0,        1));
        vecs.push_back(mk(0, 'h00, 'h0,        0, 1, 'h01, 1, 'h02, 'h102,      3, 0, 0, 'h0,        1));
        vecs.push_back(mk(0, 'h00, 'h0,        1, 1, 'h02, 1, 'h02, 'h102,      3, 0, 1, 'h102,      1));
        vecs.push_back(mk(0, 'h00, 'h0,        1, 0, 'h00, 1, 'h03, 'h103,      2, 0, 0, 'h0,        1));
        vecs.push_back(mk(0, 'h00, 'h0,        1, 0, 'h00, 1, 'h04, 'h104,      1, 0, 0, 'h0,        1));
        vecs.push_back(mk(0, 'h00, 'h0,        0, 0, 'h00, 0, 'h00, 'h0,        0, 0, 0, 'h0,        1));
        vecs.push_back(mk(1, 'h20, 'h11111111, 0, 1, 'h20, 0, 'h00, 'h0,        0, 0, 0, 'h0,        1));
        vecs.push_back(mk(1, 'h30, 'h22,       0, 0, 'h00, 1, 'h20, 'h11111111, 1, 0, 0, 'h0,        1));
        vecs.push_back(mk(1, 'h20, 'h33333333, 0, 0, 'h00, 1, 'h20, 'h11111111, 2, 0, 0, 'h0,        1));
        vecs.push_back(mk(0, 'h00, 'h0,        0, 1, 'h20, 1, 'h20, 'h11111111, 3, 0, 1, 'h33333333, 1));
        vecs.push_back(mk(0, 'h00, 'h0,        0, 1, 'h40, 1, 'h20, 'h11111111, 3, 0, 0, 'h0,        1));
        vecs.push_back(mk(0, 'h00, 'h0,        0, 1, 'h30, 1, 'h20, 'h11111111, 3, 0, 1, 'h22,       1));
        vecs.push_back(mk(0, 'h00, 'h0,        0, 0, 'h20, 1, 'h20, 'h11111111, 3, 0, 0, 'h0,        1));

        foreach (vecs[n]) begin
            mem_wr_en    = vecs[n].we;
            mem_wr_addr  = vecs[n].wa;
            mem_wr_data  = vecs[n].wd;
            dc_req_ready = vecs[n].rdy;
            ld_valid     = vecs[n].ldv;
            ld_addr      = vecs[n].lda;
            #1;
            chk($sformatf("row%0d.dc_req_valid", n), 64'(dc_req_valid), 64'(vecs[n].e_vld));
            chk($sformatf("row%0d.dc_req_addr", n),  64'(dc_req_addr),  64'(vecs[n].e_addr));
            chk($sformatf("row%0d.dc_req_data", n),  64'(dc_req_data),  64'(vecs[n].e_data));
            chk($sformatf("row%0d.count", n),        64'(count),        64'(vecs[n].e_cnt));
            chk($sformatf("row%0d.empty", n),        64'(empty),        64'(vecs[n].e_cnt == 0));
            chk($sformatf("row%0d.st_stall", n),     64'(st_stall),     64'(vecs[n].e_stall));
            chk($sformatf("row%0d.fwd_hit", n),      64'(fwd_hit),      64'(vecs[n].e_hit));
            chk($sformatf("row%0d.fwd_data", n),     64'(fwd_data),     64'(vecs[n].e_fwd));
            chk($sformatf("row%0d.overflow", n),     64'(overflow),     64'(vecs[n].e_ovf));
            tick();
        end

        // Reset with three stores queued and the head outstanding.
        idle_inputs();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        #1;
        chk("rst.empty",        64'(empty),        64'd1);
        chk("rst.count",        64'(count),        64'd0);
        chk("rst.dc_req_valid", 64'(dc_req_valid), 64'd0);
        chk("rst.dc_req_addr",  64'(dc_req_addr),  64'd0);
        chk("rst.dc_req_data",  64'(dc_req_data),  64'd0);
        chk("rst.st_stall",     64'(st_stall),     64'd0);
        chk("rst.overflow",     64'(overflow),     64'd0);
        ld_valid = 1'b1;
        ld_addr  = 'h20;
        #1;
        chk("rst.fwd_hit_20",   64'(fwd_hit),      64'd0);
        chk("rst.fwd_data_20",  64'(fwd_data),     64'd0);
        ld_addr  = 'h30;
        #1;
        chk("rst.fwd_hit_30",   64'(fwd_hit),      64'd0);
        tick();

        // Stream 10 stores against random ready; model tracks occupancy and expected order.
        idle_inputs();
        rx   = 0;
        sent = 0;
        mcnt = 0;
        for (int cyc = 0; cyc < 400 && rx < 10; cyc++) begin
            push_now     = (sent < 10) && (mcnt < DEPTH);
            mem_wr_en    = push_now;
            mem_wr_addr  = AW'(sent);
            mem_wr_data  = DW'(sent);
            dc_req_ready = 1'($urandom_range(0, 1));
            pop_now      = (mcnt != 0) && dc_req_ready;
            #1;
            chk("stream.count",    64'(count),        64'(mcnt));
            chk("stream.st_stall", 64'(st_stall),     64'(mcnt == DEPTH));
            chk("stream.valid",    64'(dc_req_valid), 64'(mcnt != 0));
            if (pop_now) begin
                chk("stream.addr", 64'(dc_req_addr), 64'(rx));
                chk("stream.data", 64'(dc_req_data), 64'(rx));
                rx++;
            end
            if (push_now) sent++;
            mcnt = mcnt + (push_now ? 1 : 0) - (pop_now ? 1 : 0);
            tick();
        end
        idle_inputs();
        #1;
        chk("stream.received", 64'(rx),       64'd10);
        chk("stream.overflow", 64'(overflow), 64'd0);
        chk("stream.empty",    64'(empty),    64'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
